// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared widths, latency default and FSM encoding for the multiplier arbiter
package mul_arb_pkg;
   localparam int OP_W            = 4;
   localparam int PROD_W          = 8;
   localparam int CNT_W           = 4;
   localparam int MUL_LAT_DEFAULT = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; pointer breaks the tie when both requesters are valid
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       pointer,
   output logic [1:0] grant
);
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = pointer ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - shares one external Booth multiplier between two requesters
module booth_mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [OP_W-1:0]   req0_a,
   input  logic [OP_W-1:0]   req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [OP_W-1:0]   req1_a,
   input  logic [OP_W-1:0]   req1_b,
   output logic              req1_ready,
   output logic              resp0_valid,
   output logic              resp1_valid,
   output logic [PROD_W-1:0] resp_p,
   output logic              mul_start,
   output logic [OP_W-1:0]   mul_a,
   output logic [OP_W-1:0]   mul_b,
   input  logic [PROD_W-1:0] mul_p,
   output logic              busy
);
   state_t           state;
   logic             owner;
   logic             ptr;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       grant;

   rr_arb2 u_rr_arb2 (
      .valid   ({req1_valid, req0_valid}),
      .pointer (ptr),
      .grant   (grant)
   );

   // Gated by rst so no handshake or busy leaks out while the FSM is being cleared.
   assign req0_ready = !rst && (state == ST_IDLE) && grant[0];
   assign req1_ready = !rst && (state == ST_IDLE) && grant[1];
   assign busy       = !rst && (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= 1'b0;
         ptr         <= 1'b0;
         cnt         <= '0;
         mul_start   <= 1'b0;
         mul_a       <= '0;
         mul_b       <= '0;
         resp_p      <= '0;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  owner     <= grant[1];
                  mul_a     <= grant[1] ? req1_a : req0_a;
                  mul_b     <= grant[1] ? req1_b : req0_b;
                  mul_start <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mul_start <= 1'b0;
               cnt       <= CNT_W'(MUL_LAT - 1);
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // Product is taken verbatim; the multiplier owns all arithmetic.
               if (cnt == '0) begin
                  resp_p      <= mul_p;
                  resp0_valid <= !owner;
                  resp1_valid <= owner;
                  state       <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               resp0_valid <= 1'b0;
               resp1_valid <= 1'b0;
               ptr         <= !owner;
               state       <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 6, giving cycles from the mul_start cycle to a valid mul_p (legal range 1..15).
REQ-002 SHALL have ports as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_a  in  4  requester 0 multiplicand, signed two's complement.
- req0_b  in  4  requester 0 multiplier, signed two's complement.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- resp0_valid  out  1  one-cycle pulse: resp_p holds requester 0 result.
- resp1_valid  out  1  one-cycle pulse: resp_p holds requester 1 result.
- resp_p  out  8  signed product register.
- mul_start  out  1  start pulse to the shared Booth multiplier.
- mul_a, mul_b  out  4  operands to the shared Booth multiplier.
- mul_p  in  8  product from the shared Booth multiplier.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE: accept SHALL occur when either req valid; grant SHALL go to the sole valid requester, or to the priority-pointer requester when both are valid.
REQ-005 reqN_ready SHALL be combinational, equal to (state==IDLE and grant==N), and never high for both requesters in the same cycle.
REQ-006 On accept, operands and owner ID SHALL be latched into mul_a/mul_b/owner, and the next state SHALL be ISSUE.
REQ-007 Operands SHALL hold stable on mul_a/mul_b from ISSUE through DONE; requester inputs SHALL be ignored after accept.
REQ-008 ISSUE SHALL assert mul_start for exactly one cycle, load the down-counter with MUL_LAT-1, and go to WAIT.
REQ-009 WAIT SHALL decrement the counter each cycle; when the counter is 0, mul_p SHALL be registered into resp_p and the next state SHALL be DONE.
REQ-010 DONE SHALL assert resp<owner>_valid for one cycle, set the priority pointer to the non-owner, and return to IDLE.
REQ-011 Latency SHALL be: accept in cycle A gives mul_start in A+1 and resp valid in A+2+MUL_LAT; the next accept is possible no earlier than A+3+MUL_LAT.
REQ-012 resp_p SHALL hold its value until the next DONE capture.
REQ-013 The block SHALL do no arithmetic on products; mul_p SHALL pass to resp_p bit-exact.
REQ-014 A requester holding valid during another's operation SHALL be served next, with no starvation under continuous dual requests (strict alternation).

Reset
REQ-015 When rst is sampled high, the FSM SHALL go to IDLE, the priority pointer to requester 0, and the counter to 0.
REQ-016 During reset, mul_start, mul_a, mul_b, resp_p, resp0_valid, resp1_valid, req0_ready, req1_ready and busy SHALL all be 0.
REQ-017 Reset in the middle of an operation SHALL abort it with no response pulse; integration SHALL drive the multiplier's active-low rst_n from ~rst.

Structure
REQ-018 Package mul_arb_pkg SHALL hold the FSM state encoding, operand width 4, product width 8, and the MUL_LAT default.
REQ-019 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: valid[1:0], pointer; output: one-hot grant).
REQ-020 The Booth multiplier SHALL stay external to this block.

Verification
REQ-021 The bench SHALL pair the block with a MUL_LAT=6 multiplier model; all checks run at negedge clk.
REQ-022 Single request: req0 a=3, b=6 accepted in cycle A -> mul_start in A+1, resp0_valid in A+8, resp_p=0x12 (18), resp1_valid never asserted.
REQ-023 Simultaneous requests after reset: req0 (4,7) and req1 (-3,5) -> req0 served first with resp_p=0x1C; req1 accepted at A+9 with resp_p=0xF1 (-15).
REQ-024 Signed extreme: req1 a=-8, b=-8 -> resp_p=0x40 (64); req1 a=-8, b=7 -> resp_p=0xC8 (-56).
REQ-025 Continuous dual valid for 4 operations -> grant order 0,1,0,1; no ready while busy; operand changes after accept do not alter results.
REQ-026 rst pulsed high in WAIT -> next cycle is IDLE, busy=0, no resp pulse; a following req1 (2,4) -> resp_p=0x08.
